// File: rtl/sched_task_sel_rr_pkg.sv
// sched_pkg: shared defaults, task-ID type and selector FSM states.
package sched_pkg;
  localparam int SCHED_ID_W_DEF = 4;
  localparam int SCHED_NCH_DEF = 4;
  typedef logic [SCHED_ID_W_DEF-1:0] task_id_t;
  typedef enum logic {EMPTY, FULL} sel_state_t;
endpackage

// File: rtl/sched_task_sel_rr_if.sv
// sched_task_sel_rr_if: request-side and dispatch-side handshake of the task selector.
interface sched_task_sel_rr_if
  import sched_pkg::*;
#(
  parameter int N_CH = SCHED_NCH_DEF,
  parameter int ID_W = SCHED_ID_W_DEF
);
  localparam int CH_W = $clog2(N_CH);
  logic [N_CH-1:0] in_valid;
  logic [N_CH*ID_W-1:0] in_id;
  logic [N_CH-1:0] in_ack;
  logic out_valid;
  logic [ID_W-1:0] out_id;
  logic [CH_W-1:0] out_ch;
  logic out_ready;
  modport master(output in_valid, in_id, out_ready, input in_ack, out_valid, out_id, out_ch);
  modport slave(input in_valid, in_id, out_ready, output in_ack, out_valid, out_id, out_ch);
endinterface

// File: rtl/sched_rr_arb.sv
// sched_rr_arb: combinational round-robin pick, first request at or above ptr with wrap.
module sched_rr_arb
  import sched_pkg::*;
#(
  parameter int N_CH = SCHED_NCH_DEF,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] gnt_idx,
  output logic            any
);
  always_comb begin
    any = |req;
    gnt_idx = '0;
    // Descending scan so the closest request after ptr is written last and wins.
    for (int k = N_CH - 1; k >= 0; k--) begin
      logic [CH_W-1:0] j;
      j = CH_W'((int'(ptr) + k) % N_CH);
      gnt_idx = req[j] ? j : gnt_idx;
    end
    gnt = '0;
    gnt[gnt_idx] = any;
  end
endmodule

// File: rtl/sched_task_sel_rr.sv
// sched_task_sel_rr: N:1 round-robin task-ID selector with registered valid/ready output.
// Define SCHED_SEL_STARVE_CNT_EN to add per-channel wait counters and the starve_max output.
module sched_task_sel_rr
  import sched_pkg::*;
#(
  parameter int N_CH = SCHED_NCH_DEF,
  parameter int ID_W = SCHED_ID_W_DEF,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic clk,
  input  logic rst_n,
  sched_task_sel_rr_if.slave bus
`ifdef SCHED_SEL_STARVE_CNT_EN
  ,
  output logic [7:0] starve_max
`endif
);
  sel_state_t state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [CH_W-1:0] ch_q, ch_d, ptr_q, ptr_d, gnt_idx;
  logic [N_CH-1:0] gnt;
  logic any, cap;

  sched_rr_arb #(.N_CH(N_CH)) u_arb (
    .req(bus.in_valid),
    .ptr(ptr_q),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .any(any)
  );

  assign cap = (state_q == EMPTY) | bus.out_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= EMPTY;
    else state_q <= state_d;

  always_comb state_d = cap ? (any ? FULL : EMPTY) : state_q;

  always_comb begin
    bus.out_valid = state_q == FULL;
    // Gating on rst_n keeps a captured-looking grant from leaking out while held in reset.
    bus.in_ack = (cap & rst_n) ? gnt : '0;
  end

  always_comb begin
    id_d = cap ? (any ? bus.in_id[int'(gnt_idx)*ID_W +: ID_W] : '0) : id_q;
    ch_d = cap ? (any ? gnt_idx : '0) : ch_q;
    ptr_d = (cap & any) ? ((gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1)) : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      id_q <= '0;
      ch_q <= '0;
      ptr_q <= '0;
    end else begin
      id_q <= id_d;
      ch_q <= ch_d;
      ptr_q <= ptr_d;
    end

  assign bus.out_id = id_q;
  assign bus.out_ch = ch_q;

`ifdef SCHED_SEL_STARVE_CNT_EN
  logic [7:0] cnt_q[N_CH];
  logic [7:0] cnt_d[N_CH];
  logic [7:0] max_d;

  always_comb begin
    max_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = bus.in_ack[i] ? '0 : (bus.in_valid[i] & ~&cnt_q[i]) ? cnt_q[i] + 8'd1 : cnt_q[i];
      max_d = (cnt_q[i] > max_d) ? cnt_q[i] : max_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      starve_max <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      starve_max <= max_d;
    end
`endif
endmodule

// File: tb/tb_sched_task_sel_rr.sv
// tb_sched_task_sel_rr: directed checks of reset, round-robin order, backpressure and async reset.
module tb_sched_task_sel_rr;
  import sched_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  int e[5] = '{0, 1, 2, 3, 0};

  sched_task_sel_rr_if #(.N_CH(4), .ID_W(4)) bus ();
`ifdef SCHED_SEL_STARVE_CNT_EN
  logic [7:0] starve_max;
`endif

  sched_task_sel_rr #(.N_CH(4), .ID_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef SCHED_SEL_STARVE_CNT_EN
    ,
    .starve_max(starve_max)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic outs(input string tag, input logic [31:0] v, input logic [31:0] id, input logic [31:0] ch);
    chk({tag, "_valid"}, 32'(bus.out_valid), v);
    chk({tag, "_id"}, 32'(bus.out_id), id);
    chk({tag, "_ch"}, 32'(bus.out_ch), ch);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 4'b1011;
    bus.in_id = 16'h4321;
    bus.out_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_ack", 32'(bus.in_ack), 0);
    end
    outs("rst", 0, 0, 0);
    bus.in_valid = 4'b0000;
    rst_n = 1'b1;
    tick();
    outs("idle", 0, 0, 0);
    chk("idle_ack", 32'(bus.in_ack), 0);
    // single channel 2 with ID A
    bus.in_id = 16'h0A00;
    bus.in_valid = 4'b0100;
    #1 chk("single_ack", 32'(bus.in_ack), 32'b0100);
    tick();
    outs("single", 1, 'hA, 2);
    bus.in_valid = 4'b0000;
    #1 chk("single_noack", 32'(bus.in_ack), 0);
    tick();
    outs("single_drain", 0, 0, 0);
    // pointer back to 0 before the full round-robin sweep
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    bus.in_id = 16'h4321;
    bus.in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_ack", 32'(bus.in_ack), 32'd1 << e[k]);
      tick();
      outs("rr", 1, e[k] + 1, e[k]);
    end
    bus.in_valid = 4'b0000;
    tick();
    outs("gap", 0, 0, 0);
    // backpressure with ID 5 on channel 1
    bus.in_id = 16'h4351;
    bus.in_valid = 4'b0010;
    #1 chk("bp_load_ack", 32'(bus.in_ack), 32'b0010);
    tick();
    outs("bp_load", 1, 5, 1);
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b1101;
    repeat (3) begin
      #1 chk("bp_ack", 32'(bus.in_ack), 0);
      tick();
      outs("bp_hold", 1, 5, 1);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ack", 32'(bus.in_ack), 32'b0100);
    tick();
    outs("bp_next", 1, 3, 2);
    // sparse wrap from pointer 3
    bus.in_valid = 4'b0011;
    #1 chk("wrap0_ack", 32'(bus.in_ack), 32'b0001);
    tick();
    outs("wrap0", 1, 1, 0);
    #1 chk("wrap1_ack", 32'(bus.in_ack), 32'b0010);
    tick();
    outs("wrap1", 1, 5, 1);
    #1 chk("wrap2_ack", 32'(bus.in_ack), 32'b0001);
    tick();
    outs("wrap2", 1, 1, 0);
    // async reset while stalled
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b1111;
    tick();
    outs("pre_arst", 1, 1, 0);
    #2 rst_n = 1'b0;
    #1 outs("arst", 0, 0, 0);
    chk("arst_ack", 32'(bus.in_ack), 0);
    tick();
    chk("arst_edge_ack", 32'(bus.in_ack), 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk("post_rst_ack", 32'(bus.in_ack), 32'b0001);
    tick();
    outs("post_rst", 1, 1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
